// File: rtl/spi_reg_cmd_ctrl.sv
// spi_reg_cmd_ctrl: turns SPI frames into 16-bit register read/write bus commands.
// The optional bus timeout is enabled by defining SPI_CMD_TIMEOUT_EN.
module spi_reg_cmd_ctrl #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] ERR_WORD       = 16'hDEAD
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_SPI_CS_n,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_Byte,
    output logic        o_TX_DV,
    output logic [15:0] o_TX_Byte,
    output logic        o_Req,
    output logic        o_Req_WE,
    output logic [6:0]  o_Addr,
    output logic [15:0] o_WData,
    input  logic        i_Ack,
    input  logic [15:0] i_RData,
    input  logic        i_Err_Clr,
    output logic        o_Busy,
    output logic        o_Frame_Err,
    output logic        o_Timeout_Err
);

    typedef enum logic [2:0] {IDLE, DATA_HI, DATA_LO, WR_REQ, RD_REQ, TX_LOAD, DONE} state_t;

    state_t state, s1, state_n;
    logic   cs_meta, cs_sync, cs_d;
    logic   frame_end, ended, ended_n, ferr_set, expire;

    assign frame_end = cs_sync & ~cs_d;
    assign o_Req     = (state == WR_REQ) || (state == RD_REQ);
    assign o_Req_WE  = state == WR_REQ;
    assign o_TX_DV   = state == TX_LOAD;
    assign o_Busy    = state != IDLE;

    // Synchronise the raw chip select and keep one extra stage for edge detection
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cs_meta <= 1'b1;
            cs_sync <= 1'b1;
            cs_d    <= 1'b1;
        end else begin
            cs_meta <= i_SPI_CS_n;
            cs_sync <= cs_meta;
            cs_d    <= cs_sync;
        end
    end

    // State register plus the flag remembering a frame end during a bus access
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= IDLE;
            ended <= 1'b0;
        end else begin
            state <= state_n;
            ended <= ended_n;
        end
    end

    // Byte decode first, then the frame end is applied to the resulting state
    always_comb begin
        s1 = state;
        case (state)
            IDLE:    s1 = !i_RX_DV ? IDLE : i_RX_Byte[7] ? RD_REQ : DATA_HI;
            DATA_HI: s1 = i_RX_DV ? DATA_LO : DATA_HI;
            DATA_LO: s1 = i_RX_DV ? WR_REQ : DATA_LO;
            WR_REQ:  s1 = (i_Ack || expire) ? (ended ? IDLE : DONE) : WR_REQ;
            RD_REQ:  s1 = (i_Ack || expire) ? TX_LOAD : RD_REQ;
            TX_LOAD: s1 = ended ? IDLE : DONE;
            default: s1 = state;
        endcase
        state_n  = s1;
        ended_n  = ended;
        ferr_set = 1'b0;
        if (frame_end) begin
            if (s1 == DATA_HI || s1 == DATA_LO) begin
                state_n  = IDLE;
                ferr_set = 1'b1;
            end else if (s1 == DONE) begin
                state_n = IDLE;
            end else if (s1 != IDLE) begin
                ended_n = 1'b1;
            end
        end
        if (state_n == IDLE) ended_n = 1'b0;
    end

    // Command fields, write data and the response word
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Addr    <= '0;
            o_WData   <= '0;
            o_TX_Byte <= '0;
        end else begin
            if (state == IDLE && i_RX_DV) o_Addr <= i_RX_Byte[6:0];
            if (state == DATA_HI && i_RX_DV) o_WData[15:8] <= i_RX_Byte;
            if (state == DATA_LO && i_RX_DV) o_WData[7:0] <= i_RX_Byte;
            if (state == RD_REQ && (i_Ack || expire)) o_TX_Byte <= i_Ack ? i_RData : ERR_WORD;
        end
    end

    // Sticky frame error; a new error wins over a clear in the same cycle
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) o_Frame_Err <= 1'b0;
        else          o_Frame_Err <= ferr_set ? 1'b1 : i_Err_Clr ? 1'b0 : o_Frame_Err;
    end

`ifdef SPI_CMD_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;
    logic        to_set;

    assign expire = o_Req && (to_cnt == TO_LAST);
    assign to_set = expire && !i_Ack;

    // Count cycles spent waiting in a request state; restart on every new request
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) to_cnt <= '0;
        else          to_cnt <= (o_Req && state_n == state) ? to_cnt + 16'd1 : '0;
    end

    // Sticky timeout error; an ack in the expiry cycle counts as success
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) o_Timeout_Err <= 1'b0;
        else          o_Timeout_Err <= to_set ? 1'b1 : i_Err_Clr ? 1'b0 : o_Timeout_Err;
    end
`else
    assign expire        = 1'b0;
    assign o_Timeout_Err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_cmd_ctrl.sv
// tb_spi_reg_cmd_ctrl: directed vector bench for the SPI register command sequencer.
module tb_spi_reg_cmd_ctrl;

    logic        i_Clk = 1'b0;
    logic        i_Rst_L = 1'b0;
    logic        i_SPI_CS_n = 1'b1;
    logic        i_RX_DV = 1'b0;
    logic [7:0]  i_RX_Byte = '0;
    logic        i_Ack;
    logic [15:0] i_RData;
    logic        i_Err_Clr = 1'b0;
    logic        o_TX_DV, o_Req, o_Req_WE, o_Busy, o_Frame_Err, o_Timeout_Err;
    logic [15:0] o_TX_Byte, o_WData;
    logic [6:0]  o_Addr;

    int          n_chk = 0, n_bad = 0;
    int          ack_dly = -1;
    logic [15:0] rdata = '0;
    logic        stray = 1'b0;
    int          req_cnt = 0, tx_cnt = 0, req_len = 0;
    logic        req_q = 1'b0;
    logic        m_we;
    logic [6:0]  m_addr;
    logic [15:0] m_wdata;

    typedef struct {
        logic [39:0] b;
        int          n;
        int          ack;
        logic [15:0] rd;
        int          req;
        logic        we;
        logic [6:0]  addr;
        logic [15:0] wdata;
        int          tx;
        logic [15:0] txb;
        logic        ferr;
    } vec_t;

    vec_t v[8];

    spi_reg_cmd_ctrl #(.TIMEOUT_CYCLES(8), .ERR_WORD(16'hDEAD)) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_SPI_CS_n(i_SPI_CS_n),
        .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
        .o_TX_DV(o_TX_DV), .o_TX_Byte(o_TX_Byte),
        .o_Req(o_Req), .o_Req_WE(o_Req_WE), .o_Addr(o_Addr), .o_WData(o_WData),
        .i_Ack(i_Ack), .i_RData(i_RData), .i_Err_Clr(i_Err_Clr),
        .o_Busy(o_Busy), .o_Frame_Err(o_Frame_Err), .o_Timeout_Err(o_Timeout_Err)
    );

    always #5 i_Clk = ~i_Clk;

    // Bus slave: acks ack_dly cycles after o_Req rises (never when negative)
    initial begin
        int age;
        age = 0;
        i_Ack = 1'b0;
        i_RData = '0;
        forever begin
            @(negedge i_Clk);
            i_Ack = stray;
            if (o_Req) begin
                if (ack_dly >= 0 && age == ack_dly) begin
                    i_Ack = 1'b1;
                    i_RData = rdata;
                end
                age++;
            end else begin
                age = 0;
            end
        end
    end

    // Bus and TX observer
    always @(negedge i_Clk) begin
        if (o_Req && !req_q) begin
            req_cnt++;
            m_we = o_Req_WE;
            m_addr = o_Addr;
            m_wdata = o_WData;
        end
        if (o_Req) req_len++;
        if (o_TX_DV) tx_cnt++;
        req_q = o_Req;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic send(input logic [39:0] b, input int n, input bit close);
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge i_Clk);
            i_RX_DV = 1'b1;
            i_RX_Byte = b[39-8*i -: 8];
            @(negedge i_Clk);
            i_RX_DV = 1'b0;
            @(negedge i_Clk);
        end
        if (close) begin
            @(negedge i_Clk);
            i_SPI_CS_n = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (o_Busy && k < 200) begin
            @(negedge i_Clk);
            k++;
        end
        check(name, {31'd0, o_Busy}, 32'd0);
        tick(3);
    endtask

    task automatic clear_errs();
        @(negedge i_Clk);
        i_Err_Clr = 1'b1;
        @(negedge i_Clk);
        i_Err_Clr = 1'b0;
        tick(1);
    endtask

    initial begin
        int r0, t0, l0, k;
        v[0] = '{40'h05_12_34_00_00, 3, 3, 16'h0000, 1, 1'b1, 7'h05, 16'h1234, 0, 16'h0000, 1'b0};
        v[1] = '{40'h85_00_00_00_00, 1, 3, 16'hBEEF, 1, 1'b0, 7'h05, 16'h0000, 1, 16'hBEEF, 1'b0};
        v[2] = '{40'h10_AA_00_00_00, 2, 3, 16'h0000, 0, 1'b0, 7'h00, 16'h0000, 0, 16'hBEEF, 1'b1};
        v[3] = '{40'h01_00_07_FF_FF, 5, 3, 16'h0000, 1, 1'b1, 7'h01, 16'h0007, 0, 16'hBEEF, 1'b0};
        v[4] = '{40'h9F_00_00_00_00, 1, 0, 16'h1357, 1, 1'b0, 7'h1F, 16'h0000, 1, 16'h1357, 1'b0};
        v[5] = '{40'h7F_C0_DE_00_00, 3, 1, 16'h0000, 1, 1'b1, 7'h7F, 16'hC0DE, 0, 16'h1357, 1'b0};
        v[6] = '{40'h22_00_00_00_00, 1, 3, 16'h0000, 0, 1'b0, 7'h00, 16'h0000, 0, 16'h1357, 1'b1};
        v[7] = '{40'h00_00_00_00_00, 0, 3, 16'h0000, 0, 1'b0, 7'h00, 16'h0000, 0, 16'h1357, 1'b0};

        tick(3);
        check("rst_req", {31'd0, o_Req}, 0);
        check("rst_we", {31'd0, o_Req_WE}, 0);
        check("rst_busy", {31'd0, o_Busy}, 0);
        check("rst_txdv", {31'd0, o_TX_DV}, 0);
        check("rst_txb", {16'd0, o_TX_Byte}, 0);
        check("rst_addr", {25'd0, o_Addr}, 0);
        check("rst_wdata", {16'd0, o_WData}, 0);
        check("rst_ferr", {31'd0, o_Frame_Err}, 0);
        check("rst_toerr", {31'd0, o_Timeout_Err}, 0);
        i_Rst_L = 1'b1;
        tick(3);

        for (int i = 0; i < 8; i++) begin
            r0 = req_cnt;
            t0 = tx_cnt;
            ack_dly = v[i].ack;
            rdata = v[i].rd;
            send(v[i].b, v[i].n, 1'b1);
            wait_idle($sformatf("v%0d_busy", i));
            check($sformatf("v%0d_reqs", i), req_cnt - r0, v[i].req);
            if (v[i].req > 0) begin
                check($sformatf("v%0d_we", i), {31'd0, m_we}, {31'd0, v[i].we});
                check($sformatf("v%0d_addr", i), {25'd0, m_addr}, {25'd0, v[i].addr});
                if (v[i].we) check($sformatf("v%0d_wdata", i), {16'd0, m_wdata}, {16'd0, v[i].wdata});
            end
            check($sformatf("v%0d_txdv", i), tx_cnt - t0, v[i].tx);
            check($sformatf("v%0d_txb", i), {16'd0, o_TX_Byte}, {16'd0, v[i].txb});
            check($sformatf("v%0d_ferr", i), {31'd0, o_Frame_Err}, {31'd0, v[i].ferr});
            check($sformatf("v%0d_toerr", i), {31'd0, o_Timeout_Err}, 0);
            clear_errs();
            check($sformatf("v%0d_ferr_clr", i), {31'd0, o_Frame_Err}, 0);
        end

        // read whose frame ends before the ack arrives
        r0 = req_cnt; t0 = tx_cnt; l0 = req_len;
        ack_dly = 10; rdata = 16'h4321;
        send(40'h81_00_00_00_00, 1, 1'b1);
        wait_idle("early_busy");
        check("early_reqs", req_cnt - r0, 1);
        check("early_reqlen", req_len - l0, 11);
        check("early_addr", {25'd0, m_addr}, 32'h01);
        check("early_txdv", tx_cnt - t0, 1);
        check("early_txb", {16'd0, o_TX_Byte}, 32'h4321);
        check("early_ferr", {31'd0, o_Frame_Err}, 0);
        r0 = req_cnt; ack_dly = 2;
        send(40'h03_55_AA_00_00, 3, 1'b1);
        wait_idle("after_busy");
        check("after_reqs", req_cnt - r0, 1);
        check("after_addr", {25'd0, m_addr}, 32'h03);
        check("after_wdata", {16'd0, m_wdata}, 32'h55AA);

        // last write byte coincides with the frame end
        r0 = req_cnt;
        send(40'h04_11_00_00_00, 2, 1'b0);
        i_SPI_CS_n = 1'b1;
        tick(2);
        i_RX_DV = 1'b1; i_RX_Byte = 8'h22;
        tick(1);
        i_RX_DV = 1'b0;
        wait_idle("same_busy");
        check("same_reqs", req_cnt - r0, 1);
        check("same_addr", {25'd0, m_addr}, 32'h04);
        check("same_wdata", {16'd0, m_wdata}, 32'h1122);
        check("same_ferr", {31'd0, o_Frame_Err}, 0);

        // first byte of a write coincides with the frame end
        r0 = req_cnt;
        send(40'h0, 0, 1'b0);
        tick(2);
        i_SPI_CS_n = 1'b1;
        tick(2);
        i_RX_DV = 1'b1; i_RX_Byte = 8'h30;
        tick(1);
        i_RX_DV = 1'b0;
        wait_idle("first_busy");
        check("first_reqs", req_cnt - r0, 0);
        check("first_ferr", {31'd0, o_Frame_Err}, 1);
        clear_errs();

        // ack with no request pending
        r0 = req_cnt;
        stray = 1'b1;
        tick(2);
        stray = 1'b0;
        tick(3);
        check("stray_reqs", req_cnt - r0, 0);
        check("stray_busy", {31'd0, o_Busy}, 0);

`ifdef SPI_CMD_TIMEOUT_EN
        l0 = req_len; t0 = tx_cnt; ack_dly = -1;
        send(40'h82_00_00_00_00, 1, 1'b1);
        wait_idle("to_rd_busy");
        check("to_rd_reqlen", req_len - l0, 8);
        check("to_rd_err", {31'd0, o_Timeout_Err}, 1);
        check("to_rd_txdv", tx_cnt - t0, 1);
        check("to_rd_txb", {16'd0, o_TX_Byte}, 32'hDEAD);
        clear_errs();
        check("to_clr", {31'd0, o_Timeout_Err}, 0);
        l0 = req_len; t0 = tx_cnt;
        send(40'h06_00_01_00_00, 3, 1'b1);
        wait_idle("to_wr_busy");
        check("to_wr_reqlen", req_len - l0, 8);
        check("to_wr_err", {31'd0, o_Timeout_Err}, 1);
        check("to_wr_txdv", tx_cnt - t0, 0);
        clear_errs();
        l0 = req_len; ack_dly = 7; rdata = 16'h7777;
        send(40'h83_00_00_00_00, 1, 1'b1);
        wait_idle("to_edge_busy");
        check("to_edge_reqlen", req_len - l0, 8);
        check("to_edge_err", {31'd0, o_Timeout_Err}, 0);
        check("to_edge_txb", {16'd0, o_TX_Byte}, 32'h7777);
`endif

        // asynchronous reset in the middle of a read access
        ack_dly = -1;
        send(40'h8A_00_00_00_00, 1, 1'b0);
        k = 0;
        while (!o_Req && k < 50) begin
            @(negedge i_Clk);
            k++;
        end
        check("arst_req_hi", {31'd0, o_Req}, 1);
        #2;
        i_Rst_L = 1'b0;
        #1;
        check("arst_req_lo", {31'd0, o_Req}, 0);
        check("arst_busy", {31'd0, o_Busy}, 0);
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b1;
        i_Rst_L = 1'b1;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
